// File: rtl/dl_bitwise_pipe.sv
// dl_bitwise_pipe: run-time selectable bitwise op on two operands, with registered parity/zero flags.
// Latency: NUM_STAGES cycles from accept to out_valid; sustains 1 beat/cycle when unstalled.
// Backpressure: stage k ready = ~vld[k] | ready[k+1]; in_ready drops only once every stage holds a beat.
module dl_bitwise_pipe #(
  parameter int NUM_BITS   = 32,
  parameter int NUM_STAGES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [NUM_BITS-1:0] in0,
  input  logic [NUM_BITS-1:0] in1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out,
  output logic                out_parity,
  output logic                out_zero
);

  // One pipeline beat: result plus its precomputed reduction flags.
  typedef struct packed {
    logic [NUM_BITS-1:0] dat;
    logic                parity;
    logic                zero;
  } beat_t;

  logic [NUM_BITS-1:0]   res;
  beat_t                 beat_in;
  logic [NUM_STAGES-1:0] stg_vld;
  logic [NUM_STAGES:0]   stg_rdy;
  beat_t                 stg_dat [NUM_STAGES];

  // Operation decode on the offered operands; only captured when the beat is accepted.
  always_comb begin
    res = in0;
    case (op)
      3'b000:  res = in0 & in1;
      3'b001:  res = in0 | in1;
      3'b010:  res = in0 ^ in1;
      3'b011:  res = ~(in0 & in1);
      3'b100:  res = ~(in0 | in1);
      3'b101:  res = ~(in0 ^ in1);
      3'b110:  res = in0 & ~in1;
      default: res = in0;
    endcase
  end

  // Flags are reduced once at entry and carried unchanged down the pipe.
  always_comb begin
    beat_in        = '0;
    beat_in.dat    = res;
    beat_in.parity = ^res;
    beat_in.zero   = ~|res;
  end

  // Ready chain, evaluated from the output end back to the input.
  always_comb begin
    stg_rdy             = '0;
    stg_rdy[NUM_STAGES] = out_ready;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      stg_rdy[k] = ~stg_vld[k] | stg_rdy[k+1];
    end
  end

  // Input is held off during reset so an offered beat is never taken then.
  assign in_ready = stg_rdy[0] & ~rst;

  // Stage registers: valid bits follow every advance, data loads only with a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        stg_dat[k] <= '0;
      end
    end else begin
      if (stg_rdy[0]) begin
        stg_vld[0] <= in_valid;
      end
      if (stg_rdy[0] && in_valid) begin
        stg_dat[0] <= beat_in;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (stg_rdy[k]) begin
          stg_vld[k] <= stg_vld[k-1];
        end
        if (stg_rdy[k] && stg_vld[k-1]) begin
          stg_dat[k] <= stg_dat[k-1];
        end
      end
    end
  end

  assign out_valid  = stg_vld[NUM_STAGES-1];
  assign out        = stg_dat[NUM_STAGES-1].dat;
  assign out_parity = stg_dat[NUM_STAGES-1].parity;
  assign out_zero   = stg_dat[NUM_STAGES-1].zero;

endmodule

// File: tb/tb_dl_bitwise_pipe.sv
// tb_dl_bitwise_pipe: directed vectors on an 8-bit/2-stage instance, random handshake on a 1-bit/1-stage instance.
// Latency: checks exact NUM_STAGES-cycle latency and back-to-back throughput.
// Backpressure: stalls, fill/drain ordering, simultaneous accept on a full pipe, and reset mid-stream.
module tb_dl_bitwise_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_parity, a_out_zero;
  logic [2:0] a_op;
  logic [7:0] a_in0, a_in1, a_out;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_parity, b_out_zero;
  logic [2:0] b_op;
  logic [0:0] b_in0, b_in1, b_out;

  int vectors     = 0;
  int miscompares = 0;

  dl_bitwise_pipe #(.NUM_BITS(8), .NUM_STAGES(2)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .op         (a_op),
    .in0        (a_in0),
    .in1        (a_in1),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out        (a_out),
    .out_parity (a_out_parity),
    .out_zero   (a_out_zero)
  );

  dl_bitwise_pipe #(.NUM_BITS(1), .NUM_STAGES(1)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .op         (b_op),
    .in0        (b_in0),
    .in1        (b_in1),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out        (b_out),
    .out_parity (b_out_parity),
    .out_zero   (b_out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    a_in_valid = v;
    a_op       = o;
    a_in0      = x;
    a_in1      = y;
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [7:0] d, input logic p, input logic z);
    chk({tag, ".vld"}, 32'(a_out_valid), 32'(v));
    if (v) begin
      chk({tag, ".dat"}, 32'(a_out), 32'(d));
      chk({tag, ".par"}, 32'(a_out_parity), 32'(p));
      chk({tag, ".zero"}, 32'(a_out_zero), 32'(z));
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return x;
    endcase
  endfunction

  logic [7:0] exp_ops [8];
  logic [7:0] bp_beats [3];
  logic       q [$];

  initial begin
    int         nb;
    int         accepted;
    int         cyc;
    logic       e;
    logic       h;
    logic [7:0] r;

    exp_ops  = '{8'h30, 8'hF0, 8'hC0, 8'hCF, 8'h0F, 8'h3F, 8'hC0, 8'hF0};
    bp_beats = '{8'h11, 8'h22, 8'h33};

    rst         = 1'b1;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_op        = 3'd0;
    b_in0       = 1'b0;
    b_in1       = 1'b0;
    drive_a(1'b0, 3'd0, 8'h00, 8'h00);

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst.a_vld", 32'(a_out_valid), 32'd0);
    chk("rst.a_dat", 32'(a_out), 32'd0);
    chk("rst.a_par", 32'(a_out_parity), 32'd0);
    chk("rst.a_zero", 32'(a_out_zero), 32'd0);
    chk("rst.a_rdy", 32'(a_in_ready), 32'd1);
    chk("rst.b_vld", 32'(b_out_valid), 32'd0);
    chk("rst.b_rdy", 32'(b_in_ready), 32'd1);

    // XOR A5^0F, latency exactly 2
    drive_a(1'b1, 3'd2, 8'hA5, 8'h0F);
    chk("xor1.rdy", 32'(a_in_ready), 32'd1);
    tick();
    drive_a(1'b0, 3'd0, 8'h00, 8'h00);
    chk_a("xor1.t1", 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_a("xor1.t2", 1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    chk_a("xor1.t3", 1'b0, 8'h00, 1'b0, 1'b0);

    // Zero result, then NOR with odd parity
    drive_a(1'b1, 3'd2, 8'hA5, 8'hA5);
    tick();
    drive_a(1'b1, 3'd4, 8'h00, 8'h01);
    tick();
    drive_a(1'b0, 3'd0, 8'h00, 8'h00);
    chk_a("xor0", 1'b1, 8'h00, 1'b0, 1'b1);
    tick();
    chk_a("nor", 1'b1, 8'hFE, 1'b1, 1'b0);
    tick();
    chk_a("nor.end", 1'b0, 8'h00, 1'b0, 1'b0);

    // All eight ops back-to-back
    for (int c = 0; c <= 10; c++) begin
      if (c < 8) drive_a(1'b1, 3'(c), 8'hF0, 8'h30);
      else       drive_a(1'b0, 3'd0, 8'h00, 8'h00);
      if (c < 8) chk($sformatf("ops.rdy%0d", c), 32'(a_in_ready), 32'd1);
      if (c >= 2 && c <= 9) chk_a($sformatf("ops.op%0d", c - 2), 1'b1, exp_ops[c-2], 1'b0, 1'b0);
      if (c == 10) chk_a("ops.end", 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
    end

    // Backpressure: 5 stalled cycles with input offered
    a_out_ready = 1'b0;
    nb = 0;
    for (int it = 0; it < 5; it++) begin
      drive_a(1'b1, 3'd7, bp_beats[nb], 8'h00);
      chk($sformatf("bp.rdy%0d", it), 32'(a_in_ready), (it < 2) ? 32'd1 : 32'd0);
      if (a_in_ready) nb++;
      if (it >= 2) chk_a($sformatf("bp.hold%0d", it), 1'b1, 8'h11, 1'b0, 1'b0);
      tick();
    end
    chk("bp.accepted", 32'(nb), 32'd2);
    // Release with a new beat offered: accept and emit in the same cycle
    a_out_ready = 1'b1;
    drive_a(1'b1, 3'd7, 8'h33, 8'h00);
    chk("bp.full_rdy", 32'(a_in_ready), 32'd1);
    chk_a("bp.d0", 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    drive_a(1'b0, 3'd0, 8'h00, 8'h00);
    chk_a("bp.d1", 1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    chk_a("bp.d2", 1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    chk_a("bp.end", 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset with two beats in flight and one offered during reset
    drive_a(1'b1, 3'd7, 8'h44, 8'h00);
    tick();
    drive_a(1'b1, 3'd7, 8'h55, 8'h00);
    tick();
    rst = 1'b1;
    drive_a(1'b1, 3'd7, 8'h66, 8'h00);
    tick();
    rst = 1'b0;
    drive_a(1'b0, 3'd0, 8'h00, 8'h00);
    chk("mrst.vld", 32'(a_out_valid), 32'd0);
    chk("mrst.dat", 32'(a_out), 32'd0);
    chk("mrst.par", 32'(a_out_parity), 32'd0);
    chk("mrst.zero", 32'(a_out_zero), 32'd0);
    tick();
    chk("mrst.drop1", 32'(a_out_valid), 32'd0);
    tick();
    chk("mrst.drop2", 32'(a_out_valid), 32'd0);
    drive_a(1'b1, 3'd7, 8'h77, 8'h00);
    chk("mrst.rdy", 32'(a_in_ready), 32'd1);
    tick();
    drive_a(1'b0, 3'd0, 8'h00, 8'h00);
    chk_a("mrst.new.t1", 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_a("mrst.new.t2", 1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    chk_a("mrst.new.end", 1'b0, 8'h00, 1'b0, 1'b0);

    // 1-bit, 1-stage instance under random handshake against a scoreboard
    accepted = 0;
    cyc      = 0;
    while (accepted < 1000 && cyc < 20000) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_op        = 3'($urandom_range(0, 7));
      b_in0       = 1'($urandom_range(0, 1));
      b_in1       = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      #1;
      e = ~b_out_valid | b_out_ready;
      chk("rnd.in_ready", 32'(b_in_ready), 32'(e));
      if (b_out_valid && b_out_ready) begin
        if (q.size() == 0) begin
          chk("rnd.unexpected", 32'(b_out_valid), 32'd0);
        end else begin
          h = q.pop_front();
          e = ~h;
          chk("rnd.dat", 32'(b_out), 32'(h));
          chk("rnd.par", 32'(b_out_parity), 32'(h));
          chk("rnd.zero", 32'(b_out_zero), 32'(e));
        end
      end
      if (b_in_valid && b_in_ready) begin
        r = model(b_op, {7'b0, b_in0}, {7'b0, b_in1});
        q.push_back(r[0]);
        accepted++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rnd.beats", 32'(accepted), 32'd1000);

    // Drain the remaining beat, if any
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      #1;
      if (b_out_valid) begin
        if (q.size() == 0) begin
          chk("drain.unexpected", 32'(b_out_valid), 32'd0);
        end else begin
          h = q.pop_front();
          chk("drain.dat", 32'(b_out), 32'(h));
        end
      end
      tick();
    end
    chk("rnd.drained", 32'(q.size()), 32'd0);
    chk("rnd.idle", 32'(b_out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
